// File: rtl/alu_exe_stage.sv
// Two-stage ALU execute pipeline: E1 latches the issued operands, E2 holds the result
// for forwarding and for the valid/ready completion record to writeback.
module alu_exe_stage #(
    parameter int DATA_LEN     = 32,
    parameter int ADDR_LEN     = 32,
    parameter int RRF_SEL      = 6,
    parameter int ALU_OP_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    kill_i,
    input  logic                    issue_i,
    input  logic [DATA_LEN-1:0]     op_1_i,
    input  logic [DATA_LEN-1:0]     op_2_i,
    input  logic [ADDR_LEN-1:0]     pc_i,
    input  logic [DATA_LEN-1:0]     imm_i,
    input  logic [RRF_SEL-1:0]      rrf_tag_i,
    input  logic                    dst_val_i,
    input  logic [ALU_OP_WIDTH-1:0] alu_op_i,
    output logic                    stall_o,
    output logic [DATA_LEN-1:0]     fwd_result_o,
    output logic [RRF_SEL-1:0]      fwd_dst_o,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [RRF_SEL-1:0]      wb_rrf_tag_o,
    output logic [DATA_LEN-1:0]     wb_result_o,
    output logic                    wb_dst_val_o
);

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD   = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB   = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLL   = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLT   = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLTU  = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] OP_XOR   = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRL   = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRA   = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR    = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND   = ALU_OP_WIDTH'(9);
    localparam logic [ALU_OP_WIDTH-1:0] OP_ADDI  = ALU_OP_WIDTH'(10);
    localparam logic [ALU_OP_WIDTH-1:0] OP_LUI   = ALU_OP_WIDTH'(11);
    localparam logic [ALU_OP_WIDTH-1:0] OP_AUIPC = ALU_OP_WIDTH'(12);
    localparam logic [ALU_OP_WIDTH-1:0] OP_LINK  = ALU_OP_WIDTH'(13);

    logic                    e1_valid_q, e1_valid_d;
    logic [DATA_LEN-1:0]     e1_op1_q, e1_op1_d;
    logic [DATA_LEN-1:0]     e1_op2_q, e1_op2_d;
    logic [ADDR_LEN-1:0]     e1_pc_q, e1_pc_d;
    logic [DATA_LEN-1:0]     e1_imm_q, e1_imm_d;
    logic [RRF_SEL-1:0]      e1_tag_q, e1_tag_d;
    logic                    e1_dst_val_q, e1_dst_val_d;
    logic [ALU_OP_WIDTH-1:0] e1_alu_op_q, e1_alu_op_d;

    logic                    e2_valid_q, e2_valid_d;
    logic [DATA_LEN-1:0]     e2_result_q, e2_result_d;
    logic [RRF_SEL-1:0]      e2_tag_q, e2_tag_d;
    logic                    e2_dst_val_q, e2_dst_val_d;

    logic                    accept;
    logic                    adv;
    logic                    wb_fire;
    logic [DATA_LEN-1:0]     alu_result;
    logic [4:0]              shamt;

    assign stall_o = e1_valid_q & e2_valid_q & ~wb_ready_i;
    assign accept  = issue_i & ~stall_o & ~kill_i;
    assign adv     = e1_valid_q & (~e2_valid_q | wb_ready_i) & ~kill_i;
    assign wb_fire = e2_valid_q & wb_ready_i;
    assign shamt   = e1_op2_q[4:0];

    always_comb begin
        alu_result = '0;
        case (e1_alu_op_q)
            OP_ADD:   alu_result = e1_op1_q + e1_op2_q;
            OP_SUB:   alu_result = e1_op1_q - e1_op2_q;
            OP_SLL:   alu_result = e1_op1_q << shamt;
            OP_SLT:   alu_result = DATA_LEN'($signed(e1_op1_q) < $signed(e1_op2_q));
            OP_SLTU:  alu_result = DATA_LEN'(e1_op1_q < e1_op2_q);
            OP_XOR:   alu_result = e1_op1_q ^ e1_op2_q;
            OP_SRL:   alu_result = e1_op1_q >> shamt;
            OP_SRA:   alu_result = $unsigned($signed(e1_op1_q) >>> shamt);
            OP_OR:    alu_result = e1_op1_q | e1_op2_q;
            OP_AND:   alu_result = e1_op1_q & e1_op2_q;
            OP_ADDI:  alu_result = e1_op1_q + e1_imm_q;
            OP_LUI:   alu_result = e1_imm_q;
            OP_AUIPC: alu_result = DATA_LEN'(e1_pc_q) + e1_imm_q;
            OP_LINK:  alu_result = DATA_LEN'(e1_pc_q + ADDR_LEN'(4));
            default:  alu_result = '0;
        endcase
    end

    // Kill wins over everything; otherwise a fresh accept may refill E1 in the
    // same edge that E1 drains into E2.
    always_comb begin
        e1_valid_d   = e1_valid_q;
        e1_op1_d     = e1_op1_q;
        e1_op2_d     = e1_op2_q;
        e1_pc_d      = e1_pc_q;
        e1_imm_d     = e1_imm_q;
        e1_tag_d     = e1_tag_q;
        e1_dst_val_d = e1_dst_val_q;
        e1_alu_op_d  = e1_alu_op_q;
        e2_valid_d   = e2_valid_q;
        e2_result_d  = e2_result_q;
        e2_tag_d     = e2_tag_q;
        e2_dst_val_d = e2_dst_val_q;
        if (kill_i) begin
            e1_valid_d = 1'b0;
            e2_valid_d = 1'b0;
        end else begin
            if (accept) begin
                e1_valid_d   = 1'b1;
                e1_op1_d     = op_1_i;
                e1_op2_d     = op_2_i;
                e1_pc_d      = pc_i;
                e1_imm_d     = imm_i;
                e1_tag_d     = rrf_tag_i;
                e1_dst_val_d = dst_val_i;
                e1_alu_op_d  = alu_op_i;
            end else if (adv) begin
                e1_valid_d = 1'b0;
            end
            if (adv) begin
                e2_valid_d   = 1'b1;
                e2_result_d  = alu_result;
                e2_tag_d     = e1_tag_q;
                e2_dst_val_d = e1_dst_val_q;
            end else if (wb_fire) begin
                e2_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            e1_valid_q   <= 1'b0;
            e1_op1_q     <= '0;
            e1_op2_q     <= '0;
            e1_pc_q      <= '0;
            e1_imm_q     <= '0;
            e1_tag_q     <= '0;
            e1_dst_val_q <= 1'b0;
            e1_alu_op_q  <= '0;
            e2_valid_q   <= 1'b0;
            e2_result_q  <= '0;
            e2_tag_q     <= '0;
            e2_dst_val_q <= 1'b0;
        end else begin
            e1_valid_q   <= e1_valid_d;
            e1_op1_q     <= e1_op1_d;
            e1_op2_q     <= e1_op2_d;
            e1_pc_q      <= e1_pc_d;
            e1_imm_q     <= e1_imm_d;
            e1_tag_q     <= e1_tag_d;
            e1_dst_val_q <= e1_dst_val_d;
            e1_alu_op_q  <= e1_alu_op_d;
            e2_valid_q   <= e2_valid_d;
            e2_result_q  <= e2_result_d;
            e2_tag_q     <= e2_tag_d;
            e2_dst_val_q <= e2_dst_val_d;
        end
    end

    assign wb_valid_o   = e2_valid_q;
    assign wb_rrf_tag_o = e2_tag_q;
    assign wb_result_o  = e2_result_q;
    assign wb_dst_val_o = e2_dst_val_q;
    assign fwd_result_o = e2_result_q;
    assign fwd_dst_o    = (e2_valid_q & e2_dst_val_q) ? e2_tag_q : '0;

endmodule

// File: tb/tb_alu_exe_stage.sv
// Directed bench for alu_exe_stage: inputs change and outputs are checked on the
// falling clock edge, with expected values worked out by hand.
module tb_alu_exe_stage;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        kill_i;
    logic        issue_i;
    logic [31:0] op_1_i, op_2_i, pc_i, imm_i;
    logic [5:0]  rrf_tag_i;
    logic        dst_val_i;
    logic [3:0]  alu_op_i;
    logic        stall_o;
    logic [31:0] fwd_result_o;
    logic [5:0]  fwd_dst_o;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [5:0]  wb_rrf_tag_o;
    logic [31:0] wb_result_o;
    logic        wb_dst_val_o;

    int checks = 0;
    int errors = 0;

    alu_exe_stage dut (
        .clk_i(clk_i), .reset_i(reset_i), .kill_i(kill_i), .issue_i(issue_i),
        .op_1_i(op_1_i), .op_2_i(op_2_i), .pc_i(pc_i), .imm_i(imm_i),
        .rrf_tag_i(rrf_tag_i), .dst_val_i(dst_val_i), .alu_op_i(alu_op_i),
        .stall_o(stall_o), .fwd_result_o(fwd_result_o), .fwd_dst_o(fwd_dst_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rrf_tag_o(wb_rrf_tag_o),
        .wb_result_o(wb_result_o), .wb_dst_val_o(wb_dst_val_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [5:0] tag, input logic dst);
        issue_i   = 1'b1;
        alu_op_i  = op;
        op_1_i    = a;
        op_2_i    = b;
        pc_i      = pc;
        imm_i     = imm;
        rrf_tag_i = tag;
        dst_val_i = dst;
    endtask

    task automatic goIdle();
        issue_i = 1'b0;
    endtask

    // Issue one op on an empty pipe, check its result two edges later, then let it drain.
    task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] expected);
        applyStimulus(op, a, b, pc, imm, 6'd5, 1'b1);
        @(negedge clk_i);
        goIdle();
        @(negedge clk_i);
        checkOutput(tag, wb_result_o, expected);
        @(negedge clk_i);
    endtask

    initial begin
        reset_i    = 1'b0;
        kill_i     = 1'b0;
        wb_ready_i = 1'b1;
        applyStimulus(4'd0, 32'd1, 32'd2, 32'd0, 32'd0, 6'd7, 1'b1);
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_wb_result", wb_result_o, 32'd0);
        checkOutput("rst_fwd_result", fwd_result_o, 32'd0);
        checkOutput("rst_fwd_dst", 32'(fwd_dst_o), 32'd0);
        checkOutput("rst_wb_tag", 32'(wb_rrf_tag_o), 32'd0);
        checkOutput("rst_wb_dst_val", 32'(wb_dst_val_o), 32'd0);

        reset_i = 1'b1;
        applyStimulus(4'd0, 32'd5, 32'd7, 32'd0, 32'd0, 6'd3, 1'b1);
        @(negedge clk_i);
        checkOutput("add_not_yet", 32'(wb_valid_o), 32'd0);
        goIdle();
        @(negedge clk_i);
        checkOutput("add_valid", 32'(wb_valid_o), 32'd1);
        checkOutput("add_result", wb_result_o, 32'd12);
        checkOutput("add_fwd_result", fwd_result_o, 32'd12);
        checkOutput("add_fwd_dst", 32'(fwd_dst_o), 32'd3);
        checkOutput("add_wb_tag", 32'(wb_rrf_tag_o), 32'd3);
        @(negedge clk_i);
        checkOutput("add_drained", 32'(wb_valid_o), 32'd0);

        runOp("sub", 4'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF);
        runOp("sll", 4'd2, 32'd1, 32'h24, 32'd0, 32'd0, 32'h10);
        runOp("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1);
        runOp("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0);
        runOp("xor", 4'd5, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 32'hFF00);
        runOp("srl", 4'd6, 32'h8000_0000, 32'd31, 32'd0, 32'd0, 32'd1);
        runOp("sra", 4'd7, 32'h8000_0000, 32'h21, 32'd0, 32'd0, 32'hC000_0000);
        runOp("or", 4'd8, 32'hF0, 32'h0F, 32'd0, 32'd0, 32'hFF);
        runOp("and", 4'd9, 32'hF0, 32'h3C, 32'd0, 32'd0, 32'h30);
        runOp("addi", 4'd10, 32'd10, 32'd99, 32'd0, 32'hFFFF_FFFF, 32'd9);
        runOp("lui", 4'd11, 32'd1, 32'd2, 32'd0, 32'h1234_5000, 32'h1234_5000);
        runOp("auipc", 4'd12, 32'd1, 32'd2, 32'h1000, 32'h20, 32'h1020);
        runOp("link", 4'd13, 32'd1, 32'd2, 32'h1000, 32'h20, 32'h1004);
        runOp("op15", 4'd15, 32'd5, 32'd6, 32'h1000, 32'h20, 32'd0);

        // Back-pressure: three back-to-back issues against a stalled writeback.
        wb_ready_i = 1'b0;
        applyStimulus(4'd0, 32'd100, 32'd0, 32'd0, 32'd0, 6'd1, 1'b1);
        @(negedge clk_i);
        checkOutput("bp_stall_one", 32'(stall_o), 32'd0);
        applyStimulus(4'd0, 32'd200, 32'd0, 32'd0, 32'd0, 6'd2, 1'b1);
        @(negedge clk_i);
        applyStimulus(4'd0, 32'd300, 32'd0, 32'd0, 32'd0, 6'd3, 1'b1);
        checkOutput("bp_stall_full", 32'(stall_o), 32'd1);
        checkOutput("bp_head_tag", 32'(wb_rrf_tag_o), 32'd1);
        checkOutput("bp_head_result", wb_result_o, 32'd100);
        @(negedge clk_i);
        checkOutput("bp_hold_tag", 32'(wb_rrf_tag_o), 32'd1);
        checkOutput("bp_hold_result", wb_result_o, 32'd100);
        checkOutput("bp_hold_stall", 32'(stall_o), 32'd1);
        wb_ready_i = 1'b1;
        #1;
        checkOutput("bp_release_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        goIdle();
        checkOutput("bp_t2_valid", 32'(wb_valid_o), 32'd1);
        checkOutput("bp_t2_tag", 32'(wb_rrf_tag_o), 32'd2);
        checkOutput("bp_t2_result", wb_result_o, 32'd200);
        @(negedge clk_i);
        checkOutput("bp_t3_tag", 32'(wb_rrf_tag_o), 32'd3);
        checkOutput("bp_t3_result", wb_result_o, 32'd300);
        @(negedge clk_i);
        checkOutput("bp_empty", 32'(wb_valid_o), 32'd0);

        // Kill one cycle after issue.
        applyStimulus(4'd0, 32'd4, 32'd0, 32'd0, 32'd0, 6'd4, 1'b1);
        @(negedge clk_i);
        goIdle();
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        checkOutput("kill_no_valid_a", 32'(wb_valid_o), 32'd0);
        @(negedge clk_i);
        checkOutput("kill_no_valid_b", 32'(wb_valid_o), 32'd0);
        applyStimulus(4'd0, 32'd2, 32'd2, 32'd0, 32'd0, 6'd6, 1'b1);
        @(negedge clk_i);
        goIdle();
        @(negedge clk_i);
        checkOutput("post_kill_tag", 32'(wb_rrf_tag_o), 32'd6);
        checkOutput("post_kill_result", wb_result_o, 32'd4);
        @(negedge clk_i);

        // Issue coinciding with kill is dropped.
        applyStimulus(4'd0, 32'd7, 32'd0, 32'd0, 32'd0, 6'd7, 1'b1);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        goIdle();
        @(negedge clk_i);
        checkOutput("issue_kill_dropped", 32'(wb_valid_o), 32'd0);

        // Kill during a handshake with E1 also full empties both stages.
        applyStimulus(4'd0, 32'd8, 32'd0, 32'd0, 32'd0, 6'd8, 1'b1);
        @(negedge clk_i);
        applyStimulus(4'd0, 32'd10, 32'd0, 32'd0, 32'd0, 6'd10, 1'b1);
        @(negedge clk_i);
        goIdle();
        checkOutput("kill_hs_head", 32'(wb_rrf_tag_o), 32'd8);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        checkOutput("kill_hs_empty_a", 32'(wb_valid_o), 32'd0);
        @(negedge clk_i);
        checkOutput("kill_hs_empty_b", 32'(wb_valid_o), 32'd0);

        // No destination register.
        applyStimulus(4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 6'd9, 1'b0);
        @(negedge clk_i);
        goIdle();
        @(negedge clk_i);
        checkOutput("nodst_valid", 32'(wb_valid_o), 32'd1);
        checkOutput("nodst_dst_val", 32'(wb_dst_val_o), 32'd0);
        checkOutput("nodst_fwd_dst", 32'(fwd_dst_o), 32'd0);
        checkOutput("nodst_tag", 32'(wb_rrf_tag_o), 32'd9);
        @(negedge clk_i);

        // Asynchronous reset between edges while stalled.
        wb_ready_i = 1'b0;
        applyStimulus(4'd0, 32'd11, 32'd0, 32'd0, 32'd0, 6'd11, 1'b1);
        @(negedge clk_i);
        applyStimulus(4'd0, 32'd12, 32'd0, 32'd0, 32'd0, 6'd12, 1'b1);
        @(negedge clk_i);
        goIdle();
        checkOutput("ar_stall_before", 32'(stall_o), 32'd1);
        #2;
        reset_i = 1'b0;
        #1;
        checkOutput("ar_stall", 32'(stall_o), 32'd0);
        checkOutput("ar_wb_valid", 32'(wb_valid_o), 32'd0);
        checkOutput("ar_wb_result", wb_result_o, 32'd0);
        checkOutput("ar_fwd_dst", 32'(fwd_dst_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        checkOutput("ar_empty_a", 32'(wb_valid_o), 32'd0);
        wb_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("ar_empty_b", 32'(wb_valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exe_stage.md
# alu_exe_stage

Two-stage ALU execute pipeline directly downstream of the select/wakeup unit. It accepts the single ALU instruction issued per cycle (operands, pc, imm, rrf tag, alu op) and computes the result. It broadcasts result plus destination tag on a forwarding port back to the reservation stations, and hands a completion record to the ROB/RRF writeback through a valid/ready handshake. Back-pressure from writeback is returned upstream as a stall.

## Interface
- DATA_LEN, 32, operand/result width
- ADDR_LEN, 32, pc width
- RRF_SEL, 6, rename-register tag width; tag 0 means "no destination" on the forward port
- ALU_OP_WIDTH, 4, alu op encoding width
- clk_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-low reset
- kill_i  in  1  synchronous flush of both stages (mispredict)
- issue_i  in  1  instruction valid from select stage
- op_1_i, op_2_i  in  DATA_LEN  source operands
- pc_i  in  ADDR_LEN  instruction pc
- imm_i  in  DATA_LEN  sign-extended immediate
- rrf_tag_i  in  RRF_SEL  destination rename tag
- dst_val_i  in  1  instruction writes a register
- alu_op_i  in  ALU_OP_WIDTH  operation select
- stall_o  out  1  issue not accepted this cycle
- fwd_result_o  out  DATA_LEN  forwarded result
- fwd_dst_o  out  RRF_SEL  forwarded tag, 0 when nothing valid
- wb_valid_o  out  1  completion record valid
- wb_ready_i  in  1  writeback accepts record
- wb_rrf_tag_o  out  RRF_SEL  completing tag
- wb_result_o  out  DATA_LEN  completing result
- wb_dst_val_o  out  1  record carries register write

## Operation
- Op encoding (A=op_1, B=op_2): 0 ADD A+B; 1 SUB A-B; 2 SLL A<<B[4:0]; 3 SLT signed A<B ?1:0; 4 SLTU; 5 XOR; 6 SRL logical A>>B[4:0]; 7 SRA arithmetic; 8 OR; 9 AND; 10 ADDI A+imm; 11 LUI imm; 12 AUIPC pc+imm; 13 LINK pc+4; 14,15 result 0.
- All arithmetic is modulo 2^DATA_LEN; shift amount uses low 5 bits only.
- E1: operand latch. Captures the inputs when accept = issue_i & ~stall_o & ~kill_i; sets e1_valid.
- E2: result register. Loads the computed result, tag, dst_val from E1 when adv = e1_valid & (~e2_valid | wb_ready_i).
- E1 is cleared when it advances and no new accept occurs. E1 reloads in the same cycle when both advance and accept occur.
- E2 is cleared on a wb handshake (wb_valid_o & wb_ready_i) with no adv.
- stall_o = e1_valid & e2_valid & ~wb_ready_i (combinational). Upstream holds its issue while stall_o is high.
- wb_valid_o = e2_valid. wb_* fields hold stable while wb_valid_o & ~wb_ready_i.
- fwd_result_o = E2 result. fwd_dst_o = E2 tag when e2_valid & e2_dst_val, else 0. The broadcast repeats every cycle the record is held, which is harmless.
- kill_i clears e1_valid and e2_valid at the next edge and overrides accept and adv. Data registers need not clear.
- Reset is asynchronous active-low: all valid bits 0, every output 0, stall_o 0. Reset mid-operation discards in-flight records.

## Timing
- Issue accepted at edge N; E1 valid after N; result visible on fwd_*/wb_* after edge N+1. Latency is 2 cycles.
- Throughput is 1/cycle while wb_ready_i stays high.
- With wb_ready_i low: first held result in E2, second in E1. stall_o rises once both are full.
- After wb_ready_i rises: the E2 handshake and the E1→E2 move happen in the same edge, and a new issue is accepted in that same cycle.
- Simultaneous kill_i and wb handshake: the record counts as consumed by writeback, and both stages are empty afterwards.
- Simultaneous issue_i and kill_i: the instruction is dropped.

## Test plan
- Reset: hold reset_i=0 with issue_i=1 -> all outputs 0, stall_o=0. Release; issue ADD 5+7 tag 3 -> wb_result_o=12, fwd_dst_o=3 two cycles later.
- Op sweep: SUB 0-1 -> 0xFFFFFFFF. SRA 0x80000000 by 0x21 -> 0xC0000000. SLT -1<1 -> 1. SLTU 0xFFFFFFFF<1 -> 0. AUIPC pc=0x1000, imm=0x20 -> 0x1020. LINK pc=0x1000 -> 0x1004.
- Back-pressure: wb_ready_i=0, issue tags 1,2,3 back-to-back -> stall_o=1 from the cycle tag 3 is presented; tag 1 held stable. Raise ready -> tags 1,2,3 complete in order, none lost or duplicated.
- Kill: issue tag 4, kill_i in the next cycle -> wb_valid_o never asserts for tag 4; the following issue completes normally.
- No-dst: dst_val_i=0, tag 9 -> wb_valid_o=1, wb_dst_val_o=0, fwd_dst_o=0.
- Async reset asserted mid-stall between clock edges -> outputs 0 immediately, and the pipeline is empty after release.
